// File: rtl/spmv_row_accumulator.sv
// Consumer side of per-channel value FIFOs: accumulates each channel's values into row sums
// and hands finished rows to a single valid/ready output, served round-robin across channels.
module spmv_row_accumulator #(
  parameter int channel_num     = 4,
  parameter int channel_num_log = 2,
  parameter int val_bits        = 8,
  parameter int acc_bits        = 24,
  parameter int row_len_bits    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [channel_num-1:0]          empty,
  input  logic [val_bits*channel_num-1:0] out,
  output logic [channel_num-1:0]          read,
  input  logic [row_len_bits-1:0]         row_len,
  output logic                            res_valid,
  output logic [acc_bits-1:0]             res_data,
  output logic [channel_num_log-1:0]      res_channel,
  input  logic                            res_ready
);

  typedef logic [channel_num_log-1:0] ch_t;
  typedef logic [acc_bits-1:0]        acc_t;
  typedef logic [row_len_bits-1:0]    len_t;

  localparam ch_t last_ch = ch_t'(channel_num - 1);

  ch_t                    rd_ptr_q, rd_ptr_d;
  ch_t                    out_ptr_q, out_ptr_d;
  logic                   cap_valid_q, cap_valid_d;
  ch_t                    cap_ch_q, cap_ch_d;
  acc_t                   acc_q    [channel_num];
  acc_t                   acc_d    [channel_num];
  len_t                   cnt_q    [channel_num];
  len_t                   cnt_d    [channel_num];
  acc_t                   result_q [channel_num];
  acc_t                   result_d [channel_num];
  logic [channel_num-1:0] pending_q, pending_d;
  logic                   res_valid_q, res_valid_d;
  acc_t                   res_data_q, res_data_d;
  ch_t                    res_channel_q, res_channel_d;

  logic [val_bits-1:0]    cap_val;
  len_t                   eff_len;
  logic                   last_beat;
  acc_t                   sum;
  ch_t                    sel;
  ch_t                    idx;
  logic                   found;
  logic                   load;

  // Scan pointer visits one channel per cycle; a channel waiting on its result is skipped.
  always_comb begin
    read = '0;
    for (int i = 0; i < channel_num; i++) begin
      if (!rst && rd_ptr_q == ch_t'(i) && !empty[i] && !pending_q[i]) read[i] = 1'b1;
    end
  end

  always_comb begin
    cap_val = '0;
    for (int i = 0; i < channel_num; i++) begin
      if (cap_ch_q == ch_t'(i)) cap_val = out[i*val_bits +: val_bits];
    end
  end

  assign eff_len   = (row_len == '0) ? len_t'(1) : row_len;
  assign last_beat = (cnt_q[cap_ch_q] == eff_len - len_t'(1));
  assign sum       = acc_q[cap_ch_q] + acc_t'(cap_val);

  // First pending channel at or after out_ptr, wrapping around.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < channel_num; k++) begin
      idx = ch_t'((int'(out_ptr_q) + k) % channel_num);
      if (!found && pending_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign load = (!res_valid_q || res_ready) && (|pending_q);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    rd_ptr_d      = (rd_ptr_q == last_ch) ? '0 : rd_ptr_q + ch_t'(1);
    cap_valid_d   = |read;
    cap_ch_d      = rd_ptr_q;
    out_ptr_d     = out_ptr_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    pending_d     = pending_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_channel_d = res_channel_q;

    if (load) begin
      pending_d[sel] = 1'b0;
      res_valid_d    = 1'b1;
      res_data_d     = result_q[sel];
      res_channel_d  = sel;
      out_ptr_d      = (sel == last_ch) ? '0 : sel + ch_t'(1);
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    // The set bit is always a different channel from the one drained above: a pending
    // channel issues no reads, so it cannot be completing a row.
    if (cap_valid_q) begin
      if (last_beat) begin
        result_d[cap_ch_q]  = sum;
        pending_d[cap_ch_q] = 1'b1;
        acc_d[cap_ch_q]     = '0;
        cnt_d[cap_ch_q]     = '0;
      end else begin
        acc_d[cap_ch_q] = sum;
        cnt_d[cap_ch_q] = cnt_q[cap_ch_q] + len_t'(1);
      end
    end
  end

  // NOTE: the per-channel arrays are reset along with the control state, because a reset
  // must throw away partial row sums rather than let them leak into the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      out_ptr_q     <= '0;
      cap_valid_q   <= 1'b0;
      cap_ch_q      <= '0;
      for (int i = 0; i < channel_num; i++) begin
        acc_q[i]    <= '0;
        cnt_q[i]    <= '0;
        result_q[i] <= '0;
      end
      pending_q     <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_channel_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      rd_ptr_q      <= rd_ptr_d;
      out_ptr_q     <= out_ptr_d;
      cap_valid_q   <= cap_valid_d;
      cap_ch_q      <= cap_ch_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      pending_q     <= pending_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_channel_q <= res_channel_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_channel = res_channel_q;

endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Bench for spmv_row_accumulator: behavioural standard-read FIFOs feed the block, and a
// scoreboard of expected row sums is compared against each accepted result.
module tb_spmv_row_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  empty;
  logic [31:0] out_bus;
  logic [3:0]  read;
  logic [7:0]  row_len;
  logic        res_valid;
  logic [23:0] res_data;
  logic [1:0]  res_channel;
  logic        res_ready;

  logic [3:0]  read9;
  logic        res_valid9;
  logic [8:0]  res_data9;
  logic [1:0]  res_channel9;

  always #5 clk = ~clk;

  spmv_row_accumulator dut (
    .clk(clk), .rst(rst), .empty(empty), .out(out_bus), .read(read), .row_len(row_len),
    .res_valid(res_valid), .res_data(res_data), .res_channel(res_channel), .res_ready(res_ready)
  );

  // Narrow accumulator copy sharing the same FIFOs, for the wrap-around case.
  spmv_row_accumulator #(.acc_bits(9)) dut9 (
    .clk(clk), .rst(rst), .empty(empty), .out(out_bus), .read(read9), .row_len(row_len),
    .res_valid(res_valid9), .res_data(res_data9), .res_channel(res_channel9), .res_ready(res_ready)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [23:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         ptr_m;
  int         wr_p[4]  = '{0, 0, 0, 0};
  int         rd_p[4]  = '{0, 0, 0, 0};
  int         rd_cnt[4] = '{0, 0, 0, 0};
  int         last_read_cyc[4] = '{0, 0, 0, 0};
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] mem[4][64];
  logic [7:0] fifo_dout[4];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic push(input int ch, input logic [7:0] v);
    mem[ch][wr_p[ch] % 64] = v;
    wr_p[ch]++;
  endtask

  task automatic expect_res(input int ch, input int data);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = 24'(data);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input logic [7:0] v);
    step();
    rst     = 1'b1;
    row_len = v;
    step();
    rst     = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  // Standard-read FIFO model: dout updates at the edge that samples rd_en.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]           = (wr_p[i] == rd_p[i]);
      out_bus[i*8 +: 8]  = fifo_dout[i];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (read[i]) begin
        fifo_dout[i] <= mem[i][rd_p[i] % 64];
        rd_p[i]      <= rd_p[i] + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) ptr_m <= 0;
    else     ptr_m <= (ptr_m + 1) % 4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (read != 4'b0) begin
        check("read_slot", read, 32'(1) << ptr_m);
        for (int i = 0; i < 4; i++) begin
          if (read[i]) begin
            rd_cnt[i]++;
            last_read_cyc[i] = cyc;
          end
        end
      end
      if (res_valid && !prev_valid) rise_cyc = cyc;
      if (res_valid && res_ready) begin
        check("result_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_channel", res_channel, e.ch);
          check("res_data", res_data, e.data);
          check("res_valid_acc9", res_valid9, 1);
          check("res_channel_acc9", res_channel9, e.ch);
          check("res_data_acc9", res_data9, e.data % 512);
        end
      end
    end
    prev_valid = res_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, r2;
    logic [23:0] held_data;
    rst       = 1'b1;
    res_ready = 1'b1;
    row_len   = 8'd3;
    for (int i = 0; i < 4; i++) fifo_dout[i] = '0;
    #2;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_channel", res_channel, 0);
    check("rst_read", read, 0);
    repeat (2) step();
    rst = 1'b0;

    // Single row on channel 0
    set_len(8'd3);
    r0 = rd_cnt[0];
    push(0, 8'd5); push(0, 8'd7); push(0, 8'd9);
    expect_res(0, 21);
    drain(100);
    check("s21_reads", rd_cnt[0] - r0, 3);

    // Two channels of saturated values, round-robin output
    set_len(8'd2);
    r1 = rd_cnt[1]; r2 = rd_cnt[2];
    push(1, 8'd255); push(1, 8'd255);
    push(2, 8'd255); push(2, 8'd255);
    expect_res(1, 510);
    expect_res(2, 510);
    drain(100);
    check("s22_reads_ch1", rd_cnt[1] - r1, 2);
    check("s22_reads_ch2", rd_cnt[2] - r2, 2);

    // Back-pressure: first result held, the rest queue as pending
    set_len(8'd1);
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(i, 8'(i + 1));
      expect_res(i, i + 1);
    end
    repeat (20) @(negedge clk);
    check("s23_hold_valid", res_valid, 1);
    check("s23_hold_channel", res_channel, 0);
    check("s23_hold_data", res_data, 1);
    held_data = res_data;
    repeat (5) @(negedge clk);
    check("s23_stable_data", res_data, held_data);
    check("s23_stable_channel", res_channel, 0);
    step();
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("s23_back_to_back", res_valid, 1);
    end
    drain(50);

    // A pending channel must leave its remaining FIFO entries untouched
    res_ready = 1'b0;
    push(1, 8'd10); push(1, 8'd20); push(1, 8'd30);
    expect_res(1, 10); expect_res(1, 20); expect_res(1, 30);
    repeat (40) @(negedge clk);
    check("pend_block_left", wr_p[1] - rd_p[1], 1);
    step();
    res_ready = 1'b1;
    drain(100);

    // Zero row length behaves as length one; also minimum latency
    set_len(8'd0);
    push(3, 8'd42);
    expect_res(3, 42);
    drain(100);
    check("s24_latency", rise_cyc - last_read_cyc[3], 3);

    // Accumulator wrap (checked on the 9-bit copy)
    set_len(8'd3);
    push(0, 8'd255); push(0, 8'd255); push(0, 8'd255);
    expect_res(0, 765);
    drain(100);

    // Reset mid-row discards the partial sum
    set_len(8'd3);
    r0 = rd_cnt[0];
    push(0, 8'd1); push(0, 8'd1);
    repeat (14) @(negedge clk);
    check("s26_partial_reads", rd_cnt[0] - r0, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    push(0, 8'd1); push(0, 8'd1); push(0, 8'd1);
    expect_res(0, 3);
    @(negedge clk);
    check("s26_read_in_rst", read, 0);
    check("s26_valid_in_rst", res_valid, 0);
    step();
    rst = 1'b0;
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spmv_row_accumulator.md
SPMV_ROW_ACCUMULATOR -- requirements
Module: spmv_row_accumulator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- channel_num 4: number of value channels, at least 2.
- channel_num_log 2: channel index width.
- val_bits 8: width of one value.
- acc_bits 24: accumulator and result width.
- row_len_bits 8: row-length width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- empty in channel_num: per-channel FIFO empty flags.
- out in val_bits*channel_num: per-channel FIFO dout; channel i occupies bits [i*val_bits +: val_bits].
- read out channel_num: per-channel FIFO rd_en.
- row_len in row_len_bits: values per row; static while out of reset.
- res_valid out 1: result available.
- res_data out acc_bits: row sum.
- res_channel out channel_num_log: channel that produced res_data.
- res_ready in 1: downstream accepts the result.

Function
REQ-003 The block is the consumer side of the per-channel value FIFOs. The FIFOs are standard-read: dout is valid in the cycle after the edge at which rd_en was sampled high.
REQ-004 Scan pointer rd_ptr:
- advances by 1 every clock, modulo channel_num;
- has no dependence on empty or pending.
REQ-005 read is combinational: read[i] = (i == rd_ptr) & ~empty[i] & ~pending[i]. read is at most one-hot.
REQ-006 Read-issue pipeline:
- A read asserted in cycle t is recorded at edge t+1 into cap_valid and cap_ch.
- The value on out[cap_ch] is captured at edge t+2.
REQ-007 Capture:
- acc[cap_ch] <= acc[cap_ch] + zero-extended value, modulo 2^acc_bits.
- cnt[cap_ch] <= cnt[cap_ch] + 1.
REQ-008 Row completion: when a capture occurs with cnt[cap_ch] == eff_len-1, where eff_len = (row_len==0) ? 1 : row_len:
- result[cap_ch] <= acc[cap_ch] + value;
- pending[cap_ch] <= 1;
- acc[cap_ch] <= 0;
- cnt[cap_ch] <= 0.
REQ-009 While pending[i] is 1, channel i issues no reads. Other channels continue reading and accumulating.
REQ-010 Output register load condition: the output register loads when (~res_valid | res_ready) and any registered pending bit is set.
REQ-011 Output selection is round-robin:
- select the first pending channel at or after out_ptr, in cyclic order;
- on load, set res_data = result[sel] and res_channel = sel;
- on load, res_valid <= 1, pending[sel] <= 0, out_ptr <= sel+1 modulo channel_num.
REQ-012 If no pending bit is set and res_valid & res_ready, then res_valid <= 0.
REQ-013 res_data and res_channel hold stable while res_valid & ~res_ready.
REQ-014 Latency:
- final read in cycle t; result[] and pending written at edge t+2;
- res_valid rises at edge t+3 at the earliest.
REQ-015 Simultaneous events:
- Pending set and output load use registered pending, so a newly set pending bit is seen one cycle later.
- A channel whose pending bit clears at edge E may be read in cycle E onward.
REQ-016 A pending bit cannot be set again before it is drained. This holds by REQ-009 and needs no extra logic.
REQ-017 Accumulator overflow wraps silently. No flag is raised.

Reset
REQ-018 rst asserted, asynchronously:
- rd_ptr=0, out_ptr=0, cap_valid=0;
- all acc, cnt, result and pending bits = 0;
- res_valid=0, res_data=0, res_channel=0.
REQ-019 read = 0 while rst is high, regardless of empty.
REQ-020 Reset mid-row or mid-capture discards partial sums and in-flight captures. No result is emitted for them.

Verification
REQ-021 Scenario: row_len=3, channel 0 FIFO holds 5,7,9, other FIFOs empty, res_ready=1 -> one result, res_channel=0, res_data=21; exactly 3 read[0] pulses, each in a cycle with rd_ptr=0.
REQ-022 Scenario: row_len=2, channels 1 and 2 each hold 255,255 -> results 510 on channel 1, then 510 on channel 2, in round-robin order; no reads while the corresponding pending bit is set.
REQ-023 Scenario: res_ready=0, row_len=1, all four channels supplied with value i+1 -> first result (res_channel=0, res_data=1) held stable; channels 1-3 pending with no further reads. Then res_ready=1 -> results 2, 3, 4 emitted on consecutive cycles.
REQ-024 Scenario: row_len=0, channel 3 holds 42 -> treated as length 1; res_data=42, res_channel=3.
REQ-025 Scenario: acc_bits=9, row_len=3, values 255,255,255 -> res_data=765 mod 512 = 253.
REQ-026 Scenario: rst pulsed after 2 of 3 values captured on channel 0 -> no result; a following clean row of 1,1,1 yields res_data=3.
